// File: rtl/multiplier_if.sv
// Start/done handshake and operand/product bus of the iterative multiplier.
interface multiplier_if #(
  parameter int SIZE = 4
);
  logic              start;
  logic [SIZE-1:0]   a;
  logic [SIZE-1:0]   b;
  logic [2*SIZE-1:0] c;
  logic              busy;
  logic              done;

  modport master (output start, a, b, input c, busy, done);
  modport slave  (input start, a, b, output c, busy, done);
endinterface

// File: rtl/multiplier.sv
// Unsigned SIZE x SIZE shift-and-add multiplier, one partial product per cycle,
// with a registered 2*SIZE-bit product held until the next completion.
module multiplier #(
  parameter int SIZE = 4
) (
  input logic          clk,
  input logic          rst,
  multiplier_if.slave  bus
);
  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*SIZE-1:0] mcand;
  logic [SIZE-1:0]   mplier;
  logic [2*SIZE-1:0] acc;
  logic [2*SIZE-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // Control, accumulator and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      bus.c    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.c    <= acc_next;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: operand shift registers carry no reset; they are always reloaded on
  // an accepted start before RUN reads them, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      mcand  <= {{SIZE{1'b0}}, bus.a};
      mplier <= bus.b;
    end else if (state == RUN) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: tb/tb_multiplier.sv
// Directed and random checks of the multiplier against plain a*b arithmetic
// and the SIZE-cycle start-to-done latency.
module tb_multiplier;
  localparam int SIZE = 4;
  localparam int MAXV = (1 << SIZE) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   n;
  int   dones;

  multiplier_if #(.SIZE(SIZE)) bus ();
  multiplier #(.SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive operands with start high and return just after the accepting edge.
  task automatic launch(input int av, input int bv);
    @(negedge clk);
    bus.a = SIZE'(av);
    bus.b = SIZE'(bv);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges from the accepting edge until done is seen; 0 means timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 4 * SIZE; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic run_op(input int av, input int bv, input string tag);
    int cyc;
    launch(av, bv);
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    wait_done(cyc);
    check({tag, ".latency"}, 32'(cyc), 32'(SIZE));
    check({tag, ".c"}, 32'(bus.c), 32'(av * bv));
    check({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.c", 32'(bus.c), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // a = 15 against a ramp of b values, then the corner cases.
    for (int bv = 0; bv <= 4; bv++) run_op(MAXV, bv, $sformatf("f_x_%0d", bv));
    run_op(MAXV, MAXV, "max_x_max");
    run_op(0, MAXV, "zero_x_max");

    // done is a single-cycle pulse and c holds afterwards.
    @(posedge clk);
    #1;
    check("done_drop", 32'(bus.done), 32'd0);
    check("c_hold", 32'(bus.c), 32'd0);

    // Operand and start changes during RUN are ignored.
    launch(MAXV, 3);
    @(negedge clk);
    bus.a = 4'd7;
    bus.b = 4'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int k = 0; k < 3 * SIZE; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        check("midrun.c", 32'(bus.c), 32'd45);
      end
    end
    check("midrun.dones", 32'(dones), 32'd1);

    // Reset two cycles into an operation aborts it.
    launch(MAXV, 4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort.c", 32'(bus.c), 32'd0);
    check("abort.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < SIZE + 2; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("abort.dones", 32'(dones), 32'd0);
    run_op(MAXV, 2, "after_abort");

    // Back-to-back: the next start is presented during the done cycle.
    @(posedge clk);
    run_op(MAXV, 1, "b2b_first");
    run_op(MAXV, 2, "b2b_second");

    // Random operands against plain multiplication.
    for (int i = 0; i < 20; i++) begin
      int av = $urandom_range(0, MAXV);
      int bv = $urandom_range(0, MAXV);
      run_op(av, bv, $sformatf("rand%0d_%0dx%0d", i, av, bv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
